// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and constants for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Replicated to WIDTH at the use site to form the all-ones divide-by-zero quotient.
    localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - start/busy/done handshake and operand/result bundle
interface iterative_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, divByZero
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a bit, trial-subtract the divisor
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] divisor_n;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   carry;

    assign shifted   = {rem_in, bit_in};
    assign divisor_n = ~divisor;
    assign carry[0]  = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        fullAdder u_fa (
            .a    (shifted[i]),
            .b    (divisor_n[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Top position subtracts the zero-extended divisor bit (inverted to 1), so its
    // carry reduces to a|cin; when it is set the difference fits in WIDTH bits.
    assign q_bit   = shifted[WIDTH] | carry[WIDTH];
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/fullAdder.sv
// rtl/fullAdder.sv - single-bit full adder cell shared with the ripple adder datapath
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle unsigned restoring divider for UDIV, one quotient bit per cycle
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    iterative_divider_if.slave  bus
);
    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             dbz_reg;
    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign div_zero = (bus.divisor == '0);

    // The partial remainder is always below the divisor between steps, so its
    // extra sign bit lives only inside div_step.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (q_reg[WIDTH-1]),
        .divisor (divisor_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = div_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            dbz_reg     <= 1'b0;
        end else if (accept) begin
            divisor_reg <= bus.divisor;
            if (div_zero) begin
                count   <= '0;
                q_reg   <= {WIDTH{DBZ_QUOT_FILL}};
                rem_reg <= bus.dividend;
                dbz_reg <= 1'b1;
            end else begin
                count   <= CNT_W'(WIDTH);
                q_reg   <= bus.dividend;
                rem_reg <= '0;
                dbz_reg <= 1'b0;
            end
        end else if (state == RUN) begin
            count   <= count - CNT_W'(1);
            q_reg   <= {q_reg[WIDTH-2:0], q_bit};
            rem_reg <= rem_next;
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = q_reg;
    assign bus.remainder = rem_reg;
    assign bus.divByZero = dbz_reg;
endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - directed self-checking bench for iterative_divider
module tb_iterative_divider;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus.done !== 1'b1 && cycles < 200);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.quotient !== '0) begin n_err++; $display("FAIL reset_q: got %h expected 0", bus.quotient); end
        n_cmp++; if (bus.remainder !== '0) begin n_err++; $display("FAIL reset_r: got %h expected 0", bus.remainder); end
        n_cmp++; if (bus.divByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", bus.divByZero); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_ignore_back_to_back();
        logic ok;
        int   cyc;
        do_start(64'd100, 64'd7);
        n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL basic_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
        ok = 1'b1;
        for (int k = 1; k < W; k++) begin
            if (k == 10) begin
                @(negedge clk);
                bus.start    = 1'b1;
                bus.dividend = 64'd999;
                bus.divisor  = 64'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_busy_window: got early done/idle expected busy for 63 edges"); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_done_edge: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
        n_cmp++; if (bus.quotient !== 64'd14) begin n_err++; $display("FAIL basic_q: got %0d expected 14", bus.quotient); end
        n_cmp++; if (bus.remainder !== 64'd2) begin n_err++; $display("FAIL basic_r: got %0d expected 2", bus.remainder); end
        n_cmp++; if (bus.divByZero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b expected 0", bus.divByZero); end
        // new operation requested in the done cycle
        do_start(64'd50, 64'd5);
        n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
        wait_done(cyc);
        n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, W); end
        n_cmp++; if (bus.quotient !== 64'd10 || bus.remainder !== 64'd0) begin n_err++; $display("FAIL b2b_result: got q=%0d r=%0d expected q=10 r=0", bus.quotient, bus.remainder); end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vq [5];
        logic [W-1:0] vr [5];
        int cyc;
        va[0] = ONES;          vb[0] = 64'd1; vq[0] = ONES;                  vr[0] = 64'd0;
        va[1] = ONES;          vb[1] = ONES;  vq[1] = 64'd1;                 vr[1] = 64'd0;
        va[2] = 64'd5;         vb[2] = 64'd9; vq[2] = 64'd0;                 vr[2] = 64'd5;
        va[3] = 64'd0;         vb[3] = 64'd3; vq[3] = 64'd0;                 vr[3] = 64'd0;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd3; vq[4] = 64'h2AAA_AAAA_AAAA_AAAA; vr[4] = 64'd2;
        for (int i = 0; i < 5; i++) begin
            do_start(va[i], vb[i]);
            wait_done(cyc);
            n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL bound%0d_latency: got %0d expected %0d", i, cyc, W); end
            n_cmp++; if (bus.quotient !== vq[i]) begin n_err++; $display("FAIL bound%0d_q: got %h expected %h", i, bus.quotient, vq[i]); end
            n_cmp++; if (bus.remainder !== vr[i]) begin n_err++; $display("FAIL bound%0d_r: got %h expected %h", i, bus.remainder, vr[i]); end
            n_cmp++; if (bus.divByZero !== 1'b0) begin n_err++; $display("FAIL bound%0d_dbz: got %b expected 0", i, bus.divByZero); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.done !== 1'b0 || bus.quotient !== vq[i]) begin n_err++; $display("FAIL bound%0d_pulse_hold: got done=%b q=%h expected done=0 q=%h", i, bus.done, bus.quotient, vq[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        do_start(64'd1234, 64'd0);
        n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL dbz_edge: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
        n_cmp++; if (bus.divByZero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b expected 1", bus.divByZero); end
        n_cmp++; if (bus.quotient !== ONES) begin n_err++; $display("FAIL dbz_q: got %h expected %h", bus.quotient, ONES); end
        n_cmp++; if (bus.remainder !== 64'd1234) begin n_err++; $display("FAIL dbz_r: got %0d expected 1234", bus.remainder); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.divByZero !== 1'b1 ||
                bus.quotient !== ONES || bus.remainder !== 64'd1234) begin
                n_err++;
                $display("FAIL dbz_hold%0d: got done=%b busy=%b dbz=%b q=%h r=%0d expected 0 0 1 all-ones 1234",
                         k, bus.done, bus.busy, bus.divByZero, bus.quotient, bus.remainder);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_start(64'd100, 64'd7);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 64'd81;
        bus.divisor  = 64'd9;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.divByZero !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_clear: got busy=%b done=%b q=%h r=%h dbz=%b expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.divByZero);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_start_dropped: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        do_start(64'd81, 64'd9);
        wait_done(cyc);
        n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL midreset_latency: got %0d expected %0d", cyc, W); end
        n_cmp++; if (bus.quotient !== 64'd9 || bus.remainder !== 64'd0) begin n_err++; $display("FAIL midreset_result: got q=%0d r=%0d expected q=9 r=0", bus.quotient, bus.remainder); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic_ignore_back_to_back();
        test_boundaries();
        test_div_by_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
